// File: rtl/pulse_period_meter_pkg.sv
// Shared types and defaults for the pulse period meter and the benches that drive it.
package pulse_period_meter_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitEdge = 2'd1,
        StMeasure  = 2'd2
    } state_e;

    // 1 s at 50 MHz; matches the rate divider bench defaults.
    localparam int unsigned DefaultWidth   = 28;
    localparam int unsigned DefaultTimeout = 50_000_000;

endpackage

// File: rtl/pulse_period_meter_rise_detect.sv
// Rising-edge detector on a same-domain level; history resets high so a line
// already asserted at reset release is not reported as an edge.
module pulse_period_meter_rise_detect (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic rise
);

    logic pulse_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            pulse_d <= 1'b1;
        end else begin
            pulse_d <= in;
        end
    end

    assign rise = in & ~pulse_d;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures period and high time of a pulse train, with a one-cycle valid strobe
// per completed period and a sticky timeout when rising edges stop.
module pulse_period_meter
    import pulse_period_meter_pkg::*;
#(
    parameter int unsigned WIDTH   = DefaultWidth,
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             pulse_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic             busy
);

    localparam logic [WIDTH-1:0] TimeoutLast = WIDTH'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] One         = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hcnt_q, hcnt_d;
    logic             hi_open_q, hi_open_d;
    logic [WIDTH-1:0] period_d, high_time_d;
    logic             valid_d, timeout_d;
    logic [WIDTH-1:0] cnt_inc, hcnt_inc;
    logic             rise;

    pulse_period_meter_rise_detect u_rise_detect (
        .clock (clock),
        .reset (reset),
        .in    (pulse_in),
        .rise  (rise)
    );

    // Counters saturate rather than wrap so high_time never exceeds period.
    assign cnt_inc  = (cnt_q == '1)  ? cnt_q  : cnt_q + One;
    assign hcnt_inc = (hcnt_q == '1) ? hcnt_q : hcnt_q + One;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hcnt_d      = hcnt_q;
        hi_open_d   = hi_open_q;
        period_d    = period;
        high_time_d = high_time;
        valid_d     = 1'b0;
        timeout_d   = timeout;

        if (!enable) begin
            state_d   = StIdle;
            cnt_d     = '0;
            hcnt_d    = '0;
            hi_open_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StWaitEdge;
                end
                StWaitEdge: begin
                    if (rise) begin
                        state_d   = StMeasure;
                        cnt_d     = One;
                        hcnt_d    = One;
                        hi_open_d = 1'b1;
                    end else if (cnt_q == TimeoutLast) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StMeasure: begin
                    // A rise on the timeout cycle still completes the period.
                    if (rise) begin
                        period_d    = cnt_q;
                        high_time_d = hcnt_q;
                        valid_d     = 1'b1;
                        timeout_d   = 1'b0;
                        cnt_d       = One;
                        hcnt_d      = One;
                        hi_open_d   = 1'b1;
                    end else if (cnt_q == TimeoutLast) begin
                        timeout_d = 1'b1;
                        state_d   = StWaitEdge;
                        cnt_d     = '0;
                        hcnt_d    = '0;
                        hi_open_d = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                        if (!pulse_in) begin
                            hi_open_d = 1'b0;
                        end else if (hi_open_q) begin
                            hcnt_d = hcnt_inc;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            hi_open_q <= 1'b0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            hi_open_q <= hi_open_d;
            period    <= period_d;
            high_time <= high_time_d;
            valid     <= valid_d;
            timeout   <= timeout_d;
        end
    end

    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_pulse_period_meter.sv
// Randomised bench for pulse_period_meter: a sample-history reference model feeds
// a scoreboard queue that a negedge monitor drains whenever valid is seen.
module tb_pulse_period_meter;

    localparam int unsigned W = 8;
    localparam int unsigned T = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         pulse_in = 1'b1;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         valid;
    logic         timeout;
    logic         busy;

    pulse_period_meter #(
        .WIDTH   (W),
        .TIMEOUT (T)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .pulse_in  (pulse_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .timeout   (timeout),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [W-1:0] per;
        logic [W-1:0] hi;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state: mode 0 idle, 1 waiting for arming edge, 2 measuring.
    int           m_mode = 0;
    logic         m_prev = 1'b1;
    logic         m_valid = 1'b0;
    logic         m_timeout = 1'b0;
    logic [W-1:0] m_period = '0;
    logic [W-1:0] m_high = '0;
    int           ref_edge = 0;
    int           n = 0;
    logic         since[$];  // samples taken from the last rise up to now

    function automatic int lead_ones();
        int k = 0;
        while (k < since.size() && since[k]) k++;
        return k;
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model, evaluated on the same inputs the DUT samples.
    initial begin
        logic p, rise;
        exp_t e;
        forever begin
            @(posedge clock);
            p = pulse_in;
            m_valid = 1'b0;
            if (reset) begin
                m_prev = 1'b1;
                m_mode = 0;
                m_period = '0;
                m_high = '0;
                m_timeout = 1'b0;
                since.delete();
            end else begin
                rise = p && !m_prev;
                if (!enable) begin
                    m_mode = 0;
                end else if (m_mode == 0) begin
                    m_mode = 1;
                    ref_edge = n;
                end else if (m_mode == 1) begin
                    if (rise) begin
                        m_mode = 2;
                        since.delete();
                    end else if (n - ref_edge == int'(T)) begin
                        m_timeout = 1'b1;
                        ref_edge = n;
                    end
                end else begin
                    if (rise) begin
                        m_period = W'(since.size());
                        m_high = W'(lead_ones());
                        m_valid = 1'b1;
                        m_timeout = 1'b0;
                        e.per = m_period;
                        e.hi = m_high;
                        exp_q.push_back(e);
                        since.delete();
                    end else if (since.size() == int'(T) - 1) begin
                        m_timeout = 1'b1;
                        m_mode = 1;
                        ref_edge = n;
                    end
                end
                if (m_mode == 2) since.push_back(p);
                m_prev = p;
            end
            n++;
        end
    end

    // Monitor: status every cycle, measured values popped from the scoreboard on valid.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            chk("valid", valid, m_valid);
            chk("busy", busy, (m_mode != 0));
            chk("timeout", timeout, m_timeout);
            chk("period_held", period, m_period);
            chk("high_time_held", high_time, m_high);
            if (valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_period", period, e.per);
                    chk("sb_high_time", high_time, e.hi);
                end
            end
        end
    end

    task automatic drive(input logic en, input logic p);
        @(negedge clock);
        enable = en;
        pulse_in = p;
    endtask

    task automatic wave(input int per, input int hi, input int reps);
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < per; i++) drive(1'b1, (i < hi));
    endtask

    initial begin
        int per, hi;
        // Line high through reset release: never an edge, timeout after T cycles.
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2 * T + 5) drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);

        // Rate-divider style train, then a 3/7 square wave.
        wave(5, 2, 6);
        wave(10, 3, 5);

        // Period 12 then the line stops; a good period afterwards clears timeout.
        wave(12, 4, 3);
        repeat (T + 10) drive(1'b1, 1'b0);
        wave(9, 2, 4);

        // Rise exactly on the timeout cycle, then just beyond it.
        wave(T - 1, 3, 3);
        wave(T, 3, 3);
        wave(6, 1, 3);

        // Enable dropped mid-measurement, then re-enabled.
        wave(8, 3, 2);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        repeat (3) drive(1'b0, 1'b0);
        wave(8, 3, 3);

        // Reset mid-measurement.
        wave(7, 2, 2);
        drive(1'b1, 1'b1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        wave(7, 2, 3);

        // Randomised trains with occasional enable drops.
        for (int k = 0; k < 150; k++) begin
            per = $urandom_range(20, 2);
            hi = $urandom_range(per - 1, 1);
            wave(per, hi, $urandom_range(3, 1));
            if ($urandom_range(9, 0) == 0)
                repeat ($urandom_range(3, 1)) drive(1'b0, 1'($urandom_range(1, 0)));
        end

        repeat (4) drive(1'b1, 1'b0);
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
